// File: rtl/tcm_dec_tbu_pkg.sv
// Trellis definition shared by the 4D-8PSK TCM decoder, plus the traceback unit's decoder types.
// Encoder model: next = {s[2:0], u ^ s[5:3]}, so branch idx names the predecessor's upper state bits.
package tcm_trellis_pkg;

    localparam int unsigned TREL_STATE_N = 64;
    localparam int unsigned TREL_STATE_W = 6;
    localparam int unsigned TREL_DEC_W   = 3;

    typedef logic [TREL_STATE_W-1:0] trel_state_t;
    typedef logic [TREL_DEC_W-1:0]   trel_idx_t;

    // Branch 0 of state 0 is the zero-input self-loop.
    function automatic trel_state_t trel_prev_state(input trel_state_t state, input trel_idx_t idx);
        return {idx, state[TREL_STATE_W-1:TREL_DEC_W]};
    endfunction

    function automatic trel_idx_t trel_in_bits(input trel_state_t state, input trel_idx_t idx);
        return state[TREL_DEC_W-1:0] ^ idx;
    endfunction

endpackage

package tcm_dec_tbu_pkg;

    import tcm_trellis_pkg::*;

    typedef trel_idx_t trel_decision_t;
    typedef trel_decision_t [TREL_STATE_N-1:0] trel_dec_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TRACE = 2'd2,
        ST_OUT   = 2'd3
    } tbu_state_t;

endpackage

// File: rtl/tcm_dec_tbu_ram.sv
// Simple dual-port synchronous RAM with one-cycle registered read, frozen by the clock enable.
module tcm_dec_tbu_ram #(
    parameter int unsigned pDAT_W  = 8,
    parameter int unsigned pADDR_W = 10,
    parameter int unsigned pDEPTH  = 1024
) (
    input  logic               clk,
    input  logic               ena,
    input  logic               we,
    input  logic [pADDR_W-1:0] waddr,
    input  logic [pDAT_W-1:0]  wdata,
    input  logic [pADDR_W-1:0] raddr,
    output logic [pDAT_W-1:0]  rdata
);

    logic [pDAT_W-1:0] mem_r [0:pDEPTH-1];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (ena) begin
            if (we) begin
                mem_r[waddr] <= wdata;
            end
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/tcm_dec_tbu.sv
// Frame-based Viterbi traceback: store decisions, trace back from the best state,
// then stream the decoded bits out in transmission order.
module tcm_dec_tbu
    import tcm_trellis_pkg::*;
    import tcm_dec_tbu_pkg::*;
#(
    parameter int unsigned pSTATE_N   = TREL_STATE_N,
    parameter int unsigned pFRAME_MAX = 1024,
    parameter int unsigned pADDR_W    = 10,
    parameter int unsigned pDAT_W     = TREL_DEC_W
) (
    input  logic                        iclk,
    input  logic                        ireset,
    input  logic                        iclkena,
    input  logic                        ival,
    input  logic                        isop,
    input  logic                        ieop,
    input  logic [pSTATE_N*3-1:0]       idecision,
    input  logic [$clog2(pSTATE_N)-1:0] ibeststate,
    output logic                        ordy,
    output logic                        oval,
    output logic                        osop,
    output logic                        oeop,
    output logic [pDAT_W-1:0]           odat
);

    localparam int unsigned LEN_W = pADDR_W + 1;
    localparam logic [LEN_W-1:0] FRAME_MAX = LEN_W'(pFRAME_MAX);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO      = LEN_W'(0);

    tbu_state_t          state_r, state_nxt_s;
    logic [LEN_W-1:0]    wcnt_r, len_r, tcnt_r, ocnt_r;
    logic [LEN_W-1:0]    step_idx_s, step_len_s;
    logic [pADDR_W-1:0]  dec_raddr_s, obuf_waddr_s;
    logic                accept_s, frame_end_s, dec_we_s, trace_proc_s, obuf_issue_s, ordy_nxt_s;
    trel_state_t         cur_r;
    trel_dec_vec_t       dec_vec_s;
    trel_decision_t      idx_s;
    logic [pSTATE_N*3-1:0] dec_rdata_s;
    logic [pDAT_W-1:0]   obuf_rdata_s;
    logic                rd_vld_r, rd_sop_r, rd_eop_r;

    assign dec_vec_s = dec_rdata_s;

    // Frame intake: which step index the incoming vector lands on and the saturated length.
    always_comb begin
        accept_s    = ival && ((state_r == ST_IDLE && isop) || state_r == ST_WRITE);
        step_idx_s  = isop ? ZERO : wcnt_r;
        dec_we_s    = accept_s && (step_idx_s < FRAME_MAX);
        frame_end_s = accept_s && ieop;
        if (step_idx_s < FRAME_MAX) begin
            step_len_s = step_idx_s + ONE;
        end else begin
            step_len_s = FRAME_MAX;
        end
    end

    // State register.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_r <= ST_IDLE;
        end else if (iclkena) begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ival && isop) begin
                    state_nxt_s = ieop ? ST_TRACE : ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_TRACE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_TRACE: begin
                if (tcnt_r == len_r) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_TRACE;
                end
            end
            ST_OUT: begin
                if (ocnt_r == len_r + ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state control decode; RAM read data for tcnt-1 arrives when tcnt is current.
    always_comb begin
        trace_proc_s = (state_r == ST_TRACE) && (tcnt_r != ZERO);
        dec_raddr_s  = pADDR_W'(len_r - ONE - tcnt_r);
        obuf_waddr_s = pADDR_W'(len_r - tcnt_r);
        obuf_issue_s = (state_r == ST_OUT) && (ocnt_r < len_r);
        ordy_nxt_s   = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_WRITE);
        idx_s        = dec_vec_s[cur_r];
    end

    // Step counters, frame length and traceback state.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wcnt_r <= ZERO;
            len_r  <= ZERO;
            tcnt_r <= ZERO;
            ocnt_r <= ZERO;
            cur_r  <= '0;
        end else if (iclkena) begin
            if (accept_s) begin
                wcnt_r <= step_len_s;
            end
            if (frame_end_s) begin
                len_r <= step_len_s;
                cur_r <= ibeststate;
            end else if (trace_proc_s) begin
                cur_r <= trel_prev_state(cur_r, idx_s);
            end
            tcnt_r <= (state_r == ST_TRACE) ? tcnt_r + ONE : ZERO;
            ocnt_r <= (state_r == ST_OUT) ? ocnt_r + ONE : ZERO;
        end
    end

    // Output read pipeline and registered outputs.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            rd_vld_r <= 1'b0;
            rd_sop_r <= 1'b0;
            rd_eop_r <= 1'b0;
            oval     <= 1'b0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            odat     <= '0;
            ordy     <= 1'b1;
        end else if (iclkena) begin
            rd_vld_r <= obuf_issue_s;
            rd_sop_r <= obuf_issue_s && (ocnt_r == ZERO);
            rd_eop_r <= obuf_issue_s && (ocnt_r == len_r - ONE);
            oval     <= rd_vld_r;
            osop     <= rd_sop_r;
            oeop     <= rd_eop_r;
            odat     <= rd_vld_r ? obuf_rdata_s : '0;
            ordy     <= ordy_nxt_s;
        end
    end

    tcm_dec_tbu_ram #(
        .pDAT_W  (pSTATE_N*3),
        .pADDR_W (pADDR_W),
        .pDEPTH  (pFRAME_MAX)
    ) u_dec_ram (
        .clk   (iclk),
        .ena   (iclkena),
        .we    (dec_we_s),
        .waddr (step_idx_s[pADDR_W-1:0]),
        .wdata (idecision),
        .raddr (dec_raddr_s),
        .rdata (dec_rdata_s)
    );

    tcm_dec_tbu_ram #(
        .pDAT_W  (pDAT_W),
        .pADDR_W (pADDR_W),
        .pDEPTH  (pFRAME_MAX)
    ) u_out_ram (
        .clk   (iclk),
        .ena   (iclkena),
        .we    (trace_proc_s),
        .waddr (obuf_waddr_s),
        .wdata (trel_in_bits(cur_r, idx_s)),
        .raddr (ocnt_r[pADDR_W-1:0]),
        .rdata (obuf_rdata_s)
    );

endmodule

// File: tb/tb_tcm_dec_tbu.sv
// Directed bench for tcm_dec_tbu: reference traceback model feeds a queue that the output monitor drains.
module tb_tcm_dec_tbu;

    import tcm_trellis_pkg::*;

    localparam int FMAX = 1024;
    localparam int DECW = 192;

    logic            iclk = 1'b0;
    logic            ireset, iclkena, ival, isop, ieop;
    logic [DECW-1:0] idecision;
    logic [5:0]      ibeststate;
    logic            ordy, oval, osop, oeop;
    logic [2:0]      odat;

    int checks = 0;
    int errors = 0;
    logic [4:0]      exp_q [$];
    logic [DECW-1:0] dec_mem [FMAX];
    bit   ena_rand = 1'b0;
    bit   en_q = 1'b1;
    bit   in_frame = 1'b0;
    bit   eop_seen = 1'b0;
    logic [6:0] prev_out = 7'd0;

    always #5 iclk = ~iclk;

    tcm_dec_tbu dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .ival       (ival),
        .isop       (isop),
        .ieop       (ieop),
        .idecision  (idecision),
        .ibeststate (ibeststate),
        .ordy       (ordy),
        .oval       (oval),
        .osop       (osop),
        .oeop       (oeop),
        .odat       (odat)
    );

    initial begin
        forever begin
            @(posedge iclk);
            en_q = iclkena;
        end
    end

    // Output monitor: one sample per clock, away from the active edge.
    initial begin
        forever begin
            @(negedge iclk);
            if (ireset) begin
                in_frame = 1'b0;
                eop_seen = 1'b0;
            end else if (!en_q) begin
                checks++;
                assert ({oval, osop, oeop, odat, ordy} === prev_out)
                else begin errors++; $error("FAIL hold observed=%b expected=%b", {oval, osop, oeop, odat, ordy}, prev_out); end
            end else begin
                if (eop_seen) begin
                    checks++;
                    assert (ordy === 1'b1)
                    else begin errors++; $error("FAIL ordy_after_eop observed=%b expected=1", ordy); end
                    eop_seen = 1'b0;
                end
                if (oval === 1'b1) begin
                    checks++;
                    assert (exp_q.size() != 0)
                    else begin errors++; $error("FAIL extra_oval observed=%0d queued expected=nonzero", exp_q.size()); end
                    if (exp_q.size() != 0) begin
                        checks++;
                        assert ({osop, oeop, odat} === exp_q[0])
                        else begin errors++; $error("FAIL out_word observed=%b expected=%b", {osop, oeop, odat}, exp_q[0]); end
                        void'(exp_q.pop_front());
                    end
                    in_frame = !oeop;
                    eop_seen = oeop;
                end else if (in_frame) begin
                    checks++;
                    assert (oval === 1'b1)
                    else begin errors++; $error("FAIL oval_gap observed=%b expected=1", oval); end
                    in_frame = 1'b0;
                end
            end
            prev_out = {oval, osop, oeop, odat, ordy};
        end
    end

    function automatic logic [DECW-1:0] rand_dec();
        logic [DECW-1:0] d;
        for (int w = 0; w < DECW / 32; w++) d[w*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic tick(output bit en);
        iclkena = ena_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        en = iclkena;
        @(posedge iclk);
        @(negedge iclk);
    endtask

    task automatic drive_step(input bit sop, input bit eop, input logic [DECW-1:0] dec, input logic [5:0] best);
        bit en;
        ival = 1'b1; isop = sop; ieop = eop; idecision = dec; ibeststate = best;
        do tick(en); while (!en);
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    endtask

    task automatic push_expected(input int n, input logic [5:0] best);
        int len;
        logic [5:0] cur;
        logic [2:0] idx;
        logic [2:0] bits [FMAX];
        len = (n > FMAX) ? FMAX : n;
        cur = best;
        for (int k = len - 1; k >= 0; k--) begin
            idx = dec_mem[k][3*cur +: 3];
            bits[k] = trel_in_bits(cur, idx);
            cur = trel_prev_state(cur, idx);
        end
        for (int k = 0; k < len; k++) exp_q.push_back({k == 0, k == len - 1, bits[k]});
    endtask

    task automatic send_frame(input int n, input logic [5:0] best, input bit zero);
        logic [DECW-1:0] dec;
        for (int k = 0; k < n; k++) begin
            dec = zero ? {DECW{1'b0}} : rand_dec();
            if (k < FMAX) dec_mem[k] = dec;
            drive_step(k == 0, k == n - 1, dec, best);
        end
        push_expected(n, best);
    endtask

    task automatic wait_done(input int n, input bit pulse);
        int cyc;
        int budget;
        bit en;
        cyc = 0;
        budget = 8 * n + 200;
        while (!(exp_q.size() == 0 && ordy === 1'b1) && cyc < budget) begin
            if (exp_q.size() != 0) begin
                checks++;
                assert (ordy === 1'b0)
                else begin errors++; $error("FAIL ordy_busy observed=%b expected=0", ordy); end
            end
            if (pulse && exp_q.size() != 0) begin
                ival = 1'($urandom_range(1, 0)); isop = 1'($urandom_range(1, 0));
                ieop = 1'($urandom_range(1, 0)); idecision = rand_dec(); ibeststate = 6'($urandom());
            end else begin
                ival = 1'b0; isop = 1'b0; ieop = 1'b0;
            end
            tick(en);
            cyc++;
        end
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        checks++;
        assert (cyc < budget)
        else begin errors++; $error("FAIL frame_timeout observed=%0d cycles expected=below %0d", cyc, budget); end
    endtask

    task automatic check_rst(input string tag);
        checks++;
        assert ({oval, osop, oeop, odat} === 6'b0)
        else begin errors++; $error("FAIL %s_outs observed=%b expected=000000", tag, {oval, osop, oeop, odat}); end
        checks++;
        assert (ordy === 1'b1)
        else begin errors++; $error("FAIL %s_ordy observed=%b expected=1", tag, ordy); end
    endtask

    initial begin
        bit en;
        int cyc;
        ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        idecision = {DECW{1'b0}}; ibeststate = 6'd0;
        repeat (3) @(negedge iclk);
        check_rst("reset_hold");
        ireset = 1'b0;
        tick(en);
        check_rst("reset_idle");

        // All-zero decisions from state 0 decode to zeros.
        send_frame(16, 6'd0, 1'b1);
        wait_done(16, 1'b0);

        send_frame(1000, 6'($urandom()), 1'b0);
        wait_done(1000, 1'b0);

        send_frame(1, 6'd37, 1'b0);
        wait_done(1, 1'b0);

        // Length saturates: only the first FMAX steps are kept.
        send_frame(FMAX + 5, 6'($urandom()), 1'b0);
        wait_done(FMAX, 1'b0);

        // Stray ival during TRACE/OUT must not disturb the frame.
        send_frame(40, 6'($urandom()), 1'b0);
        wait_done(40, 1'b1);

        // Restart mid-WRITE: the aborted frame produces nothing.
        for (int k = 0; k < 10; k++) drive_step(k == 0, 1'b0, rand_dec(), 6'd5);
        send_frame(20, 6'($urandom()), 1'b0);
        wait_done(20, 1'b0);

        ena_rand = 1'b1;
        send_frame(64, 6'($urandom()), 1'b0);
        wait_done(64, 1'b0);
        ena_rand = 1'b0;

        // Reset during TRACE.
        send_frame(50, 6'($urandom()), 1'b0);
        repeat (10) tick(en);
        #2 ireset = 1'b1;
        #1 check_rst("rst_trace");
        exp_q.delete();
        repeat (2) @(negedge iclk);
        ireset = 1'b0;

        // Reset during OUT, a few words in.
        send_frame(30, 6'($urandom()), 1'b0);
        cyc = 0;
        while (oval !== 1'b1 && cyc < 200) begin
            tick(en);
            cyc++;
        end
        checks++;
        assert (oval === 1'b1)
        else begin errors++; $error("FAIL out_start observed=%b expected=1", oval); end
        repeat (5) tick(en);
        #2 ireset = 1'b1;
        #1 check_rst("rst_out");
        exp_q.delete();
        repeat (2) @(negedge iclk);
        ireset = 1'b0;

        send_frame(40, 6'($urandom()), 1'b0);
        wait_done(40, 1'b0);

        repeat (3) tick(en);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcm_dec_tbu.md
# tcm_dec_tbu

Frame-based traceback (survivor memory) unit of the 4D-8PSK TCM Viterbi decoder. It sits directly downstream of the add-compare-select array and stores one 3-bit branch decision per trellis state per step for a whole frame. At frame end it traces back from a supplied best state and writes the decoded encoder-input bits into an output buffer. It then streams those bits out in forward (transmission) order.

## Interface
Parameters:
- pSTATE_N, 64, number of trellis states; must match the trellis package.
- pFRAME_MAX, 1024, maximum trellis steps per frame.
- pADDR_W, 10, step address width; 2^pADDR_W >= pFRAME_MAX.
- pDAT_W, 3, decoded encoder-input bits per trellis step.

Ports:
- iclk  in  1  clock.
- ireset  in  1  reset: asynchronous, active-high.
- iclkena  in  1  global clock enable; low freezes all state.
- ival  in  1  decision vector valid.
- isop  in  1  first step of frame, qualified by ival.
- ieop  in  1  last step of frame, qualified by ival.
- idecision  in  pSTATE_N*3  decisions; bits [3s+2:3s] are the winning branch index of state s.
- ibeststate  in  log2(pSTATE_N)  traceback start state, sampled with ival&ieop.
- ordy  out  1  block accepts a frame (IDLE or WRITE).
- oval  out  1  output bit group valid.
- osop  out  1  first output of frame.
- oeop  out  1  last output of frame.
- odat  out  pDAT_W  decoded bits.

## Operation
- FSM: IDLE -> WRITE -> TRACE -> OUT -> IDLE.
- IDLE:
  - ordy=1.
  - ival&isop writes idecision to decision RAM address 0 and enters WRITE.
  - ival without isop is ignored.
- WRITE:
  - Each ival writes at the next address.
  - ival&isop restarts at address 0; the frame in progress is dropped.
  - Steps beyond pFRAME_MAX are not written; the length saturates at pFRAME_MAX.
  - ival&ieop latches length N and ibeststate, then enters TRACE.
  - isop&ieop in the same cycle gives N=1.
- TRACE:
  - ordy=0.
  - Read address counts N-1 down to 0, one per cycle.
  - For step k: idx = decision[3·cur+2:3·cur].
  - odat bits for step k = trel_in_bits(cur, idx), written to output RAM at address k.
  - cur <= trel_prev_state(cur, idx).
  - cur is initialised to ibeststate.
- OUT:
  - ordy=0.
  - Output RAM is read from address 0 to N-1, one per enabled cycle.
  - No downstream backpressure.
- ival while ordy=0 is ignored; no error flag.

## Timing
- Reset values: oval=0, osop=0, oeop=0, odat=0, ordy=1, FSM=IDLE, all counters 0. Reset mid-frame discards the frame.
- All sequential updates are gated by iclkena.
- Decision RAM has 1-cycle read latency. The read address does not depend on state, so traceback sustains 1 step per cycle. TRACE lasts N+1 enabled cycles.
- OUT: first oval 2 enabled cycles after TRACE ends (1-cycle RAM read plus registered output). Then N consecutive oval cycles; osop on the first, oeop on the last, both on the single word when N=1.
- ordy rises in the cycle after oeop.
- Frame-to-frame minimum gap: 2N+4 enabled cycles.

## Structure
- Shared trellis package holds:
  - constants pSTATE_N, state width, decision width (3);
  - functions trel_prev_state(state, idx) and trel_in_bits(state, idx);
  - trellis property: branch 0 of state 0 is the zero-input self-loop.
- Decoder types package holds trel_decision_t and the decision vector type.
- One sub-module, tcm_dec_tbu_ram: simple dual-port synchronous RAM with registered read and parameterised width/depth. Instantiated twice: decisions (pSTATE_N*3 wide) and output (pDAT_W wide).

## Test plan
- All-zero decisions, ibeststate=0, N=16 -> 16 outputs odat=0; osop on output 1; oeop on output 16; ordy high again after oeop.
- Random decisions and random ibeststate, N=1000, compared against a bench model using the package functions -> bit-exact odat sequence; oval contiguous.
- N=1 (isop&ieop same cycle) -> single oval with osop=oeop=1. N=pFRAME_MAX+5 -> exactly 1024 outputs.
- ival pulses during TRACE/OUT -> ignored, ordy=0, output identical to an undisturbed run. isop mid-WRITE -> only the second frame is output.
- iclkena toggled 50% random over a 64-step frame -> same odat sequence as with iclkena=1; no state advance while low.
- ireset asserted mid-TRACE and mid-OUT -> outputs 0 immediately, ordy=1; the next frame decodes correctly.
